// File: rtl/ah_cam_pkg.sv
// Shared definitions for the AH CAM write/snoop initiator.
//   lkp_state_e : lookup FSM states
//   *_DEF       : default entry width and CAM depth
//   credw_for() : smallest counter width that holds 0..depth
package ah_cam_pkg;

   localparam int DATAW_DEF    = 10;
   localparam int CAMDEPTH_DEF = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lkp_state_e;

   function automatic int credw_for(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ah_sync_fifo.sv
// Synchronous valid/ready FIFO, DEPTH x WIDTH, no bypass.
//   clk, rst                       : clock, async active-high reset
//   in_valid/in_ready/in_data      : write side (in_ready = not full)
//   out_valid/out_ready/out_data   : read side (out_valid = not empty)
module ah_sync_fifo
   import ah_cam_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = DATAW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB distinguishes full from empty when the indices coincide.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty     = (wr_ptr == rd_ptr);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_data  = mem[rd_ptr[AW-1:0]];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= in_data;
   end

endmodule

// File: rtl/ah_cam_wr_initiator.sv
// Initiator for the AH CAM write and snoop ports.
//   req_*          : upstream insert requests, queued in ah_sync_fifo
//   cam_wr_*       : credit-controlled CAM writes, registered
//   lkp_* / rsp_*  : upstream lookup request / response
//   cam_snoop_*    : single-outstanding CAM snoop
//   credit_cnt     : write credits available
//   credit_err     : sticky, credit returned while already at CAMDEPTH
//
// Lookup FSM
//   state | meaning
//   IDLE  | lkp_ready high, waiting for a lookup
//   ISSUE | cam_snoop_valid high for one cycle with the latched key
//   WAIT  | counting down the remaining snoop latency
//   RESP  | match/data sampled, rsp_valid high for one cycle
module ah_cam_wr_initiator
   import ah_cam_pkg::*;
#(
   parameter int DATAW    = DATAW_DEF,
   parameter int CAMDEPTH = CAMDEPTH_DEF,
   parameter int CREDW    = credw_for(CAMDEPTH_DEF),
   parameter int QDEPTH   = 4,
   parameter int SNP_LAT  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DATAW-1:0] req_data,
   output logic             cam_wr_valid,
   output logic [DATAW-1:0] cam_wr_data,
   input  logic             cam_wr_credit,
   input  logic             lkp_valid,
   output logic             lkp_ready,
   input  logic [DATAW-1:0] lkp_key,
   output logic             cam_snoop_valid,
   output logic [DATAW-1:0] cam_snoop_key,
   input  logic             cam_snoop_match,
   input  logic [DATAW-1:0] cam_snoop_data,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output logic [DATAW-1:0] rsp_data,
   output logic [CREDW-1:0] credit_cnt,
   output logic             credit_err
);

   localparam logic [CREDW-1:0] CRED_MAX  = CREDW'(CAMDEPTH);
   localparam logic [1:0]       WAIT_INIT = 2'(SNP_LAT - 1);

   logic             fifo_valid;
   logic [DATAW-1:0] fifo_data;
   logic             credit_nz;
   logic             issue;

   assign credit_nz = (credit_cnt != '0);
   assign issue     = fifo_valid && credit_nz;

   ah_sync_fifo #(
      .DEPTH (QDEPTH),
      .WIDTH (DATAW)
   ) u_req_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (req_valid),
      .in_ready  (req_ready),
      .in_data   (req_data),
      .out_valid (fifo_valid),
      .out_ready (credit_nz),
      .out_data  (fifo_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cam_wr_valid <= 1'b0;
         cam_wr_data  <= '0;
      end else begin
         cam_wr_valid <= issue;
         if (issue) cam_wr_data <= fifo_data;
      end
   end

   // An issue and a return in the same cycle cancel out, even at CAMDEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_cnt <= CRED_MAX;
         credit_err <= 1'b0;
      end else begin
         case ({issue, cam_wr_credit})
            2'b10: credit_cnt <= credit_cnt - 1'b1;
            2'b01: begin
               if (credit_cnt == CRED_MAX) credit_err <= 1'b1;
               else                        credit_cnt <= credit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   lkp_state_e       state;
   logic [DATAW-1:0] key_q;
   logic [1:0]       wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         key_q    <= '0;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (lkp_valid) begin
                  key_q <= lkp_key;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (SNP_LAT == 1) begin
                  state <= RESP;
               end else begin
                  state    <= WAIT;
                  wait_cnt <= WAIT_INIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 2'd1) state    <= RESP;
               else                  wait_cnt <= wait_cnt - 1'b1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RESP is exactly ISSUE+SNP_LAT, so the response passes the CAM's
   // match/data straight through during that cycle.
   assign lkp_ready       = (state == IDLE);
   assign cam_snoop_valid = (state == ISSUE);
   assign cam_snoop_key   = key_q;
   assign rsp_valid       = (state == RESP);
   assign rsp_hit         = rsp_valid && cam_snoop_match;
   assign rsp_data        = rsp_hit ? cam_snoop_data : '0;

endmodule

// File: tb/tb_ah_cam_wr_initiator.sv
module tb_ah_cam_wr_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [9:0] req_data;
   logic       cam_wr_credit;

   logic       req_ready       [2];
   logic       cam_wr_valid    [2];
   logic [9:0] cam_wr_data     [2];
   logic       lkp_valid       [2];
   logic       lkp_ready       [2];
   logic [9:0] lkp_key         [2];
   logic       cam_snoop_valid [2];
   logic [9:0] cam_snoop_key   [2];
   logic       cam_snoop_match [2];
   logic [9:0] cam_snoop_data  [2];
   logic       rsp_valid       [2];
   logic       rsp_hit         [2];
   logic [9:0] rsp_data        [2];
   logic [3:0] credit_cnt      [2];
   logic       credit_err      [2];

   always #5 clk = ~clk;

   // Instance 0 uses SNP_LAT=1, instance 1 uses SNP_LAT=3 so WAIT is exercised.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      ah_cam_wr_initiator #(.SNP_LAT(g == 0 ? 1 : 3)) u_dut (
         .clk             (clk),
         .rst             (rst),
         .req_valid       (req_valid),
         .req_ready       (req_ready[g]),
         .req_data        (req_data),
         .cam_wr_valid    (cam_wr_valid[g]),
         .cam_wr_data     (cam_wr_data[g]),
         .cam_wr_credit   (cam_wr_credit),
         .lkp_valid       (lkp_valid[g]),
         .lkp_ready       (lkp_ready[g]),
         .lkp_key         (lkp_key[g]),
         .cam_snoop_valid (cam_snoop_valid[g]),
         .cam_snoop_key   (cam_snoop_key[g]),
         .cam_snoop_match (cam_snoop_match[g]),
         .cam_snoop_data  (cam_snoop_data[g]),
         .rsp_valid       (rsp_valid[g]),
         .rsp_hit         (rsp_hit[g]),
         .rsp_data        (rsp_data[g]),
         .credit_cnt      (credit_cnt[g]),
         .credit_err      (credit_err[g])
      );
   end

   int n_chk = 0;
   int n_err = 0;
   int n_wr  = 0;
   bit rand_wr = 1'b0;

   // Reference model of the write path: a queue of accepted entries and a credit pool.
   logic [9:0] m_q [$];
   int         m_cred;
   bit         m_err;
   bit         m_wr_valid;
   logic [9:0] m_wr_data;
   bit         m_push;

   function automatic void model_reset();
      m_q.delete();
      m_cred     = 10;
      m_err      = 1'b0;
      m_wr_valid = 1'b0;
      m_push     = 1'b0;
   endfunction

   function automatic void model_step();
      bit pop;
      if (rst) begin
         model_reset();
         return;
      end
      pop    = (m_q.size() > 0) && (m_cred > 0);
      m_push = req_valid && (m_q.size() < 4);
      m_wr_valid = pop;
      if (pop) m_wr_data = m_q.pop_front();
      if (m_push) m_q.push_back(req_data);
      if (pop && !cam_wr_credit) m_cred--;
      else if (!pop && cam_wr_credit) begin
         if (m_cred == 10) m_err = 1'b1;
         else              m_cred++;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
      chk("req_ready", 32'(req_ready[0]), 32'(m_q.size() < 4));
      chk("cam_wr_valid", 32'(cam_wr_valid[0]), 32'(m_wr_valid));
      if (m_wr_valid) chk("cam_wr_data", 32'(cam_wr_data[0]), 32'(m_wr_data));
      chk("credit_cnt", 32'(credit_cnt[0]), 32'(m_cred));
      chk("credit_err", 32'(credit_err[0]), 32'(m_err));
      if (cam_wr_valid[0]) n_wr++;
      if (rand_wr) begin
         req_valid     = 1'($urandom_range(0, 1));
         req_data      = 10'($urandom);
         cam_wr_credit = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic lookup(input int u, input logic [9:0] key, input logic match,
                         input logic [9:0] data);
      int lat   = (u == 0) ? 1 : 3;
      int guard = 0;
      while (!lkp_ready[u] && guard < 10) begin
         tick();
         guard++;
      end
      chk("lkp_ready_idle", 32'(lkp_ready[u]), 32'd1);
      lkp_valid[u] = 1'b1;
      lkp_key[u]   = key;
      tick();
      lkp_valid[u] = 1'b0;
      lkp_key[u]   = 10'($urandom);
      for (int k = 1; k <= lat + 1; k++) begin
         if (k > 1) tick();
         // Wrong values everywhere except the cycle the CAM result is due.
         cam_snoop_match[u] = (k == lat + 1) ? match : !match;
         cam_snoop_data[u]  = (k == lat + 1) ? data : 10'($urandom);
         #1;
         chk("snoop_valid", 32'(cam_snoop_valid[u]), 32'(k == 1));
         if (k == 1) chk("snoop_key", 32'(cam_snoop_key[u]), 32'(key));
         chk("lkp_ready_busy", 32'(lkp_ready[u]), 32'd0);
         chk("rsp_valid", 32'(rsp_valid[u]), 32'(k == lat + 1));
         if (k == lat + 1) begin
            chk("rsp_hit", 32'(rsp_hit[u]), 32'(match));
            chk("rsp_data", 32'(rsp_data[u]), match ? 32'(data) : 32'd0);
         end
      end
      tick();
      #1;
      chk("rsp_valid_done", 32'(rsp_valid[u]), 32'd0);
      chk("lkp_ready_back", 32'(lkp_ready[u]), 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = 1'b0;
      req_data      = '0;
      cam_wr_credit = 1'b0;
      for (int u = 0; u < 2; u++) begin
         lkp_valid[u]       = 1'b0;
         lkp_key[u]         = '0;
         cam_snoop_match[u] = 1'b0;
         cam_snoop_data[u]  = '0;
      end
      model_reset();
      tick();
      tick();
      for (int u = 0; u < 2; u++) begin
         chk("rst_req_ready", 32'(req_ready[u]), 32'd1);
         chk("rst_wr_valid", 32'(cam_wr_valid[u]), 32'd0);
         chk("rst_wr_data", 32'(cam_wr_data[u]), 32'd0);
         chk("rst_lkp_ready", 32'(lkp_ready[u]), 32'd1);
         chk("rst_snoop_valid", 32'(cam_snoop_valid[u]), 32'd0);
         chk("rst_snoop_key", 32'(cam_snoop_key[u]), 32'd0);
         chk("rst_rsp", 32'({rsp_valid[u], rsp_hit[u]}), 32'd0);
         chk("rst_rsp_data", 32'(rsp_data[u]), 32'd0);
         chk("rst_credit_cnt", 32'(credit_cnt[u]), 32'd10);
         chk("rst_credit_err", 32'(credit_err[u]), 32'd0);
      end
      rst = 1'b0;

      // Twelve inserts, no credits returned: only ten may reach the CAM.
      n_wr = 0;
      begin
         int n = 1;
         int guard = 0;
         while (n <= 12 && guard < 60) begin
            req_valid = 1'b1;
            req_data  = 10'(n);
            tick();
            if (m_push) n++;
            guard++;
         end
         chk("push12_done", 32'(n), 32'd13);
      end
      req_valid = 1'b0;
      repeat (6) tick();
      chk("wr_pulse_count", 32'(n_wr), 32'd10);
      chk("drained_credit", 32'(credit_cnt[0]), 32'd0);

      // One credit return releases 0x00B.
      cam_wr_credit = 1'b1;
      tick();
      cam_wr_credit = 1'b0;
      chk("credit_0_to_1", 32'(credit_cnt[0]), 32'd1);
      tick();
      chk("issue_0x00b", 32'({cam_wr_valid[0], cam_wr_data[0]}), 32'h40B);
      chk("credit_1_to_0", 32'(credit_cnt[0]), 32'd0);

      // Fill to four entries with no credits: req_ready must drop.
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_data  = 10'(13 + i);
         tick();
      end
      req_valid = 1'b0;
      tick();
      chk("fifo_full_ready", 32'(req_ready[0]), 32'd0);

      // Reset while instance 1 sits in WAIT and the queue is full.
      lkp_valid[1] = 1'b1;
      lkp_key[1]   = 10'h2AA;
      tick();
      lkp_valid[1] = 1'b0;
      tick();
      chk("in_wait_busy", 32'({cam_snoop_valid[1], lkp_ready[1]}), 32'd0);
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_idle", 32'(lkp_ready[1]), 32'd1);
      chk("async_rst_rsp", 32'(rsp_valid[1]), 32'd0);
      chk("async_rst_ready", 32'(req_ready[0]), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_rsp_after_rst", 32'(rsp_valid[1]), 32'd0);
      end
      chk("rst_release_credit", 32'(credit_cnt[0]), 32'd10);
      lookup(1, 10'h0F3, 1'b1, 10'h123);

      // Issue and return in the same cycle with three credits left.
      for (int i = 0; i < 7; i++) begin
         req_valid = 1'b1;
         req_data  = 10'(32 + i);
         tick();
      end
      req_valid = 1'b0;
      repeat (4) tick();
      chk("credit_at_3", 32'(credit_cnt[0]), 32'd3);
      req_valid = 1'b1;
      req_data  = 10'h030;
      tick();
      req_valid     = 1'b0;
      cam_wr_credit = 1'b1;
      tick();
      cam_wr_credit = 1'b0;
      chk("issue_and_return", 32'(credit_cnt[0]), 32'd3);
      chk("issue_0x030", 32'({cam_wr_valid[0], cam_wr_data[0]}), 32'h430);

      // Return back up to CAMDEPTH, then one too many.
      cam_wr_credit = 1'b1;
      repeat (7) tick();
      chk("credit_full", 32'({credit_err[0], credit_cnt[0]}), 32'd10);
      tick();
      cam_wr_credit = 1'b0;
      chk("overflow_err", 32'(credit_err[0]), 32'd1);
      chk("overflow_cnt", 32'(credit_cnt[0]), 32'd10);
      repeat (3) tick();
      chk("err_sticky", 32'(credit_err[0]), 32'd1);

      // Directed lookups on SNP_LAT=1: hit on 0x155, then a miss.
      lookup(0, 10'h155, 1'b1, 10'h155);
      lookup(0, 10'h0AB, 1'b0, 10'h3FF);

      // Random lookups on both instances with random write traffic underneath.
      rand_wr = 1'b1;
      for (int i = 0; i < 24; i++)
         lookup(i % 2, 10'($urandom), 1'($urandom_range(0, 1)), 10'($urandom));
      rand_wr       = 1'b0;
      req_valid     = 1'b0;
      cam_wr_credit = 1'b0;
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
